// File: rtl/iob_pwm_deadtime.sv
// Complementary gate-drive bridge with programmable dead time and fault latch.
// Converts a single-ended PWM stream into non-overlapping high/low-side drives.
module iob_pwm_deadtime #(
    parameter int unsigned DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            fault_flag,
    output logic            dt_active
);

    typedef enum logic [2:0] {
        OFF,
        DEAD,
        H_ON,
        L_ON,
        FAULT
    } state_t;

    state_t          state;
    logic            pwm_q;
    logic            tgt;
    logic [DT_W-1:0] dt_cnt;
    logic            dt_zero;
    logic            start;

    assign dt_zero = (dead_time == '0);

    // OFF, H_ON->low and L_ON->high all head toward the side pwm_q requests.
    assign start = (state == OFF)
                 || ((state == H_ON) && !pwm_q)
                 || ((state == L_ON) &&  pwm_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= OFF;
            pwm_q  <= 1'b0;
            tgt    <= 1'b0;
            dt_cnt <= '0;
        end else begin
            pwm_q <= pwm_in;
            if (fault) begin
                state <= FAULT;
            end else if (state == FAULT) begin
                if (fault_clr) begin
                    state <= OFF;
                end
            end else if (!en) begin
                state <= OFF;
            end else if (state == DEAD) begin
                // Counter never reloads here, so input glitches cannot alter the gap.
                tgt    <= pwm_q;
                dt_cnt <= dt_cnt - DT_W'(1);
                if (dt_cnt <= DT_W'(1)) begin
                    state <= tgt ? H_ON : L_ON;
                end
            end else if (start) begin
                if (dt_zero) begin
                    state <= pwm_q ? H_ON : L_ON;
                end else begin
                    state  <= DEAD;
                    tgt    <= pwm_q;
                    dt_cnt <= dead_time;
                end
            end
        end
    end

    assign pwm_h      = (state == H_ON);
    assign pwm_l      = (state == L_ON);
    assign dt_active  = (state == DEAD);
    assign fault_flag = (state == FAULT);

endmodule

// File: tb/tb_iob_pwm_deadtime.sv
// Bench for iob_pwm_deadtime: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a conduction-level reference model.
module tb_iob_pwm_deadtime;

    localparam int unsigned DT_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic            pwm_in = 1'b0;
    logic [DT_W-1:0] dead_time = '0;
    logic            fault = 1'b0;
    logic            fault_clr = 1'b0;
    logic            pwm_h;
    logic            pwm_l;
    logic            fault_flag;
    logic            dt_active;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iob_pwm_deadtime #(.DT_W(DT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm_in),
        .dead_time  (dead_time),
        .fault      (fault),
        .fault_clr  (fault_clr),
        .pwm_h      (pwm_h),
        .pwm_l      (pwm_l),
        .fault_flag (fault_flag),
        .dt_active  (dt_active)
    );

    // Reference model: fault latch, idle flag, remaining dead cycles, conducting side.
    bit m_fault, m_off, m_pq, m_side, m_want;
    int m_dead;

    // Dead-gap monitor state.
    int run_len  = 0;
    int run_need = 0;
    bit prev_dt  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fault = 1'b0;
        m_off   = 1'b1;
        m_dead  = 0;
        m_pq    = 1'b0;
        m_side  = 1'b0;
        m_want  = 1'b0;
    endtask

    task automatic model_start(input bit v);
        m_off = 1'b0;
        if (dead_time == '0) begin
            m_side = v;
            m_dead = 0;
        end else begin
            m_dead = int'(dead_time);
            m_want = v;
        end
    endtask

    task automatic model_step();
        bit q;
        q = m_pq;
        if (fault) begin
            m_fault = 1'b1;
            m_off   = 1'b0;
            m_dead  = 0;
        end else if (m_fault) begin
            if (fault_clr) begin
                m_fault = 1'b0;
                m_off   = 1'b1;
            end
        end else if (!en) begin
            m_off  = 1'b1;
            m_dead = 0;
        end else if (m_off) begin
            model_start(q);
        end else if (m_dead > 0) begin
            m_dead--;
            if (m_dead == 0) m_side = m_want;
            m_want = q;
        end else if (q != m_side) begin
            model_start(q);
        end
        m_pq = pwm_in;
    endtask

    task automatic compare();
        bit live;
        live = !m_fault && !m_off;
        check("pwm_h", pwm_h, live && m_dead == 0 && m_side);
        check("pwm_l", pwm_l, live && m_dead == 0 && !m_side);
        check("dt_active", dt_active, live && m_dead > 0);
        check("fault_flag", fault_flag, m_fault);
        check("overlap", pwm_h & pwm_l, 0);
        if (dt_active && !prev_dt) begin
            run_len  = 0;
            run_need = int'(dead_time);
        end
        if (dt_active) run_len++;
        if (prev_dt && !dt_active && (pwm_h || pwm_l)) check("dead_len", run_len, run_need);
        prev_dt = dt_active;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        model_reset();

        // Reset state
        tick();
        tick();
        check("rst_h", pwm_h, 0);
        check("rst_l", pwm_l, 0);
        check("rst_dt", dt_active, 0);
        check("rst_flag", fault_flag, 0);

        // Start-up into low side, then low->high transition with dead_time=3
        rst = 1'b1; en = 1'b1; dead_time = 3; pwm_in = 1'b0;
        run(4);
        check("startup_l", pwm_l, 1);
        run(3);
        pwm_in = 1'b1;
        tick();
        check("l_hold", pwm_l, 1);
        tick();
        check("l_release", pwm_l, 0);
        check("dead_enter", dt_active, 1);
        run(2);
        check("dead_third", dt_active, 1);
        tick();
        check("h_after_dead", pwm_h, 1);
        check("dt_done", dt_active, 0);

        // Zero dead time: direct swaps
        dead_time = 0;
        for (int k = 0; k < 6; k++) begin
            pwm_in = ~pwm_in;
            run(4);
            check("swap_h", pwm_h, pwm_in);
            check("swap_l", pwm_l, !pwm_in);
        end

        // Glitch inside a 5-cycle dead interval
        dead_time = 5;
        pwm_in = ~pwm_in;
        tick();
        tick();
        cnt = dt_active ? 1 : 0;
        pwm_in = ~pwm_in;
        tick();
        if (dt_active) cnt++;
        pwm_in = ~pwm_in;
        tick();
        if (dt_active) cnt++;
        for (int i = 0; i < 20 && dt_active; i++) begin
            tick();
            if (dt_active) cnt++;
        end
        check("glitch_len", cnt, 5);
        check("glitch_side", pwm_h, pwm_in);

        // Fault during H_ON
        pwm_in = 1'b1;
        run(10);
        check("pre_fault_h", pwm_h, 1);
        fault = 1'b1;
        tick();
        check("fault_h", pwm_h, 0);
        check("fault_l", pwm_l, 0);
        check("fault_set", fault_flag, 1);
        fault_clr = 1'b1;
        tick();
        check("clr_ignored", fault_flag, 1);
        fault_clr = 1'b0;
        fault = 1'b0;
        tick();
        check("fault_latched", fault_flag, 1);
        dead_time = 255;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("fault_cleared", fault_flag, 0);
        check("clr_off", pwm_h | pwm_l | dt_active, 0);

        // Maximum dead time, no wrap
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (dt_active) cnt++;
            else if (cnt > 0) break;
        end
        check("max_dead_len", cnt, 255);
        check("max_dead_h", pwm_h, 1);

        // Asynchronous reset mid-DEAD
        pwm_in = 1'b0;
        run(12);
        check("mid_dead", dt_active, 1);
        #2 rst = 1'b0;
        #1;
        check("async_h", pwm_h, 0);
        check("async_l", pwm_l, 0);
        check("async_dt", dt_active, 0);
        prev_dt = 1'b0;
        en = 1'b0;
        tick();
        rst = 1'b1;
        run(3);
        check("stay_off", pwm_h | pwm_l | dt_active | fault_flag, 0);
        en = 1'b1;
        dead_time = 2;

        // Randomized traffic
        for (int i = 0; i < 20000; i++) begin
            en        = ($urandom_range(0, 31) != 0);
            fault     = ($urandom_range(0, 199) == 0);
            fault_clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 5) == 0) pwm_in = ~pwm_in;
            if ($urandom_range(0, 63) == 0) begin
                if ($urandom_range(0, 7) == 0) dead_time = DT_W'($urandom_range(0, 255));
                else dead_time = DT_W'($urandom_range(0, 7));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
